// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-in / serial-out serializer.
package serializer_pkg;

    // Word-level control state: IDLE waits for a word, SHIFT streams it out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Encoding of load_dir: which end of the word leaves first.
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bidir_shift_core.sv
// WIDTH-bit shift register with parallel load, zero fill and a selectable
// shift direction. exit_bit is the bit at the end the word leaves from.
module bidir_shift_core
    import serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    output logic             exit_bit
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] toward_msb;
    logic [WIDTH-1:0] toward_lsb;

    // Per-bit neighbours for both shift directions, with zero entering at the far end.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_taps
            if (gi == 0) begin : g_msb_fill
                assign toward_msb[gi] = 1'b0;
            end else begin : g_msb_tap
                assign toward_msb[gi] = shreg_q[gi-1];
            end

            if (gi == WIDTH - 1) begin : g_lsb_fill
                assign toward_lsb[gi] = 1'b0;
            end else begin : g_lsb_tap
                assign toward_lsb[gi] = shreg_q[gi+1];
            end
        end
    endgenerate

    // Load wins over shift so a new word can replace the last bit of the old one.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift_en) begin
            shreg_d = (dir == DIR_LSB_FIRST) ? toward_lsb : toward_msb;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    // Bit currently sitting at the exit end for the active direction.
    assign exit_bit = (dir == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_bidir_serializer.sv
// Parallel-in, serial-out serializer with valid/ready on both sides.
// A word is accepted over the load port and streamed out one bit per beat,
// MSB-first or LSB-first as chosen with the word. A new word may be accepted
// on the same edge as the final beat of the previous one, so back-to-back
// words stream without a gap.
module piso_bidir_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_dir,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    input  logic             sout_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_q;
    logic             dir_d;

    logic             exit_bit;
    logic             in_shift;
    logic             load_accept;
    logic             beat;

    bidir_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load_accept),
        .load_data (load_data),
        .shift_en  (beat),
        .dir       (dir_q),
        .exit_bit  (exit_bit)
    );

    // State, bit counter and latched direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // Next state: a load always (re)starts a word; the last beat returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        if (load_accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            dir_d   = load_dir;
        end else if (beat) begin
            if (sout_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs and handshakes; everything is forced quiet while rst is high,
    // including the cycle where rst first lands mid-word.
    always_comb begin
        in_shift    = (state_q == SHIFT) && !rst;
        sout_valid  = in_shift;
        sout        = in_shift && exit_bit;
        sout_last   = in_shift && (cnt_q == CNT_LAST);
        busy        = in_shift;
        beat        = sout_valid && sout_ready;
        load_ready  = !rst && ((state_q == IDLE) || (sout_last && sout_ready));
        load_accept = load_valid && load_ready;
    end

endmodule
